xyz_channel_arbiter: RTL and testbench

Round-robin arbiter that shares one registered output channel among N indexed requesters. Each requester presents an `{x, y, z}` record, the same per-index triple the connection macros flatten into `NAME_INDEX__x/y/z` nets. The block sits between the flattened per-index channels and a single downstream consumer. It provides valid/ready flow control, fair rotation, and an optional multi-beat grant lock.

---
 rtl/xyz_channel_arbiter_pkg.sv | 23 ++
 rtl/xyz_channel_arbiter_if.sv | 31 +++
 rtl/xyz_channel_arbiter_rr_pick.sv | 35 +++
 rtl/xyz_channel_arbiter.sv | 120 ++++++++++++
 tb/tb_xyz_channel_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/xyz_channel_arbiter_pkg.sv
// Shared types for the xyz channel arbiter: the {x,y,z} payload record and the ARB/LOCK state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package xyz_arb_pkg;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
    } xyz_t;

    typedef enum logic {
        ARB,
        LOCK
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xyz_channel_arbiter_if.sv
// N-way requester bundle plus the single registered output channel, valid/ready on both sides.
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer, req_ready back to each requester.
interface xyz_channel_arbiter_if #(
    parameter int N = 4
);
    import xyz_arb_pkg::*;

    localparam int IW = idx_width(N);

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    xyz_t [N-1:0]   req_data;
    logic [N-1:0]   req_last;
    logic           out_valid;
    logic           out_ready;
    xyz_t           out_data;
    logic [IW-1:0]  out_index;
    logic           out_last;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_index, out_last
    );

endinterface

// File: rtl/xyz_channel_arbiter_rr_pick.sv
// Rotating-priority picker: first asserted req at ptr, ptr+1, ... with wrap; one-hot and encoded grant.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own ready.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                any          = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/xyz_channel_arbiter.sv
// Round-robin arbiter sharing one registered {x,y,z} slot among N requesters; XYZ_ARB_LOCK_EN adds multi-beat grant lock.
// Latency: 1 cycle accept-to-out_valid, 1 beat/cycle sustained, drain and reload in the same cycle.
// Backpressure: req_ready is zero for everyone while the slot is full and out_ready is low.
module xyz_channel_arbiter
    import xyz_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    xyz_channel_arbiter_if.slave bus
);

    localparam int IW = idx_width(N);

    logic [IW-1:0]  ptr;
    logic           out_valid_q;
    logic [3*W-1:0] slot_dat;
    logic [IW-1:0]  out_index_q;
    logic           out_last_q;

    logic           can_load;
    logic           accept;
    logic [N-1:0]   elig;
    logic [IW-1:0]  pick_ptr;
    logic [N-1:0]   gnt;
    logic [IW-1:0]  gnt_idx;
    logic           any;
    logic [IW-1:0]  nxt_ptr;

`ifdef XYZ_ARB_LOCK_EN
    arb_state_e     state;
    logic [IW-1:0]  lock_idx;
    logic [N-1:0]   lock_mask;

    // While locked only the owner is eligible; the picker pointer is irrelevant then.
    always_comb begin
        lock_mask           = '0;
        lock_mask[lock_idx] = 1'b1;
        elig                = bus.req_valid;
        pick_ptr            = ptr;
        if (state == LOCK) begin
            elig     = bus.req_valid & lock_mask;
            pick_ptr = lock_idx;
        end
    end
`else
    logic unused_last;

    assign unused_last = ^bus.req_last;
    assign elig        = bus.req_valid;
    assign pick_ptr    = ptr;
`endif

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (elig),
        .ptr     (pick_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign can_load      = !out_valid_q || bus.out_ready;
    assign accept        = any && can_load && !rst;
    assign bus.req_ready = accept ? gnt : '0;

    assign nxt_ptr = ((N == 1) || (gnt_idx == IW'(N - 1))) ? '0 : gnt_idx + 1'b1;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = slot_dat;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;

    // During a lock the winner is always lock_idx, so ptr keeps lock_idx+1 and only
    // becomes visible again once the last beat returns the FSM to ARB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            slot_dat    <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            ptr         <= '0;
`ifdef XYZ_ARB_LOCK_EN
            state       <= ARB;
            lock_idx    <= '0;
`endif
        end else if (accept) begin
            out_valid_q <= 1'b1;
            slot_dat    <= bus.req_data[gnt_idx];
            out_index_q <= gnt_idx;
            ptr         <= nxt_ptr;
`ifdef XYZ_ARB_LOCK_EN
            out_last_q  <= bus.req_last[gnt_idx];
            case (state)
                ARB: begin
                    if (!bus.req_last[gnt_idx]) begin
                        state    <= LOCK;
                        lock_idx <= gnt_idx;
                    end
                end
                LOCK: begin
                    if (bus.req_last[gnt_idx]) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
`else
            out_last_q  <= 1'b1;
`endif
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xyz_channel_arbiter.sv
// Randomised and directed bench for xyz_channel_arbiter against a beat-level reference model.
module tb_xyz_channel_arbiter;
    import xyz_arb_pkg::*;

    localparam int N = 4;

`ifdef XYZ_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    xyz_channel_arbiter_if #(.N(N)) bus ();

    xyz_channel_arbiter #(.N(N), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what the consumer should currently see, and whose turn is next.
    bit   m_vld;
    xyz_t m_data;
    int   m_idx;
    bit   m_last;
    int   m_ptr;
    bit   m_lock;
    int   m_lidx;
    int   acc_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_vld  = 1'b0;
        m_data = '0;
        m_idx  = 0;
        m_last = 1'b0;
        m_ptr  = 0;
        m_lock = 1'b0;
        m_lidx = 0;
    endtask

    function automatic int winner();
        if (LOCK_EN && m_lock) begin
            return bus.req_valid[m_lidx] ? m_lidx : -1;
        end
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_ptr + k) % N]) begin
                return (m_ptr + k) % N;
            end
        end
        return -1;
    endfunction

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        int g;
        bit can;
        logic [N-1:0] er;
        @(negedge clk);
        g   = winner();
        can = !m_vld || bus.out_ready;
        er  = '0;
        if (can && g >= 0) er[g] = 1'b1;
        check("req_ready", bus.req_ready, er);
        check("out_valid", bus.out_valid, m_vld);
        if (m_vld) begin
            check("out_data", bus.out_data, m_data);
            check("out_index", bus.out_index, m_idx);
            check("out_last", bus.out_last, m_last);
        end
        if (can && g >= 0) begin
            m_vld  = 1'b1;
            m_data = bus.req_data[g];
            m_idx  = g;
            m_last = LOCK_EN ? bus.req_last[g] : 1'b1;
            m_ptr  = (g + 1) % N;
            acc_q.push_back(g);
            if (LOCK_EN) begin
                if (!m_lock && !bus.req_last[g]) begin
                    m_lock = 1'b1;
                    m_lidx = g;
                end else if (m_lock && bus.req_last[g]) begin
                    m_lock = 1'b0;
                end
            end
        end else if (m_vld && bus.out_ready) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    int exp_rr[6]   = '{0, 1, 2, 3, 0, 1};
    int exp_lock[5] = '{1, 1, 1, 3, 0};

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '1;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        m_reset();

        // Reset: nobody is granted while rst is high, even with requests pending.
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '1;
        #1;
        check("rst_ready", bus.req_ready, 4'b0000);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_last", bus.out_last, 1'b0);
        bus.req_valid = '0;
        rst = 1'b0;
        repeat (5) cycle();

        // All requesters valid: strict rotation starting at 0.
        for (int i = 0; i < N; i++) begin
            bus.req_data[i] = {8'(i), 8'(i + 16), 8'(i + 32)};
        end
        bus.req_valid = '1;
        acc_q.delete();
        repeat (6) cycle();
        check("rr_count", acc_q.size(), 6);
        for (int k = 0; k < acc_q.size() && k < 6; k++) begin
            check("rr_seq", acc_q[k], exp_rr[k]);
        end

        // Single requester streams every cycle.
        bus.req_valid = 4'b0100;
        acc_q.delete();
        repeat (6) cycle();
        check("stream_count", acc_q.size(), 6);
        for (int k = 0; k < acc_q.size(); k++) begin
            check("stream_idx", acc_q[k], 2);
        end
        bus.req_valid = '0;
        repeat (2) cycle();

        // Backpressure: held beat stays put, then drains while the next winner loads.
        bus.req_data[1] = {8'd5, 8'd6, 8'd7};
        bus.req_valid   = 4'b0010;
        cycle();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1010;
        repeat (3) begin
            cycle();
            check("bp_data", bus.out_data, 24'h050607);
            check("bp_ready", bus.req_ready, 4'b0000);
        end
        bus.out_ready = 1'b1;
        acc_q.delete();
        cycle();
        check("bp_release_cnt", acc_q.size(), 1);
        check("bp_next_index", bus.out_index, 3);
        check("bp_next_valid", bus.out_valid, 1'b1);
        bus.req_valid = '0;
        repeat (2) cycle();

        // Random traffic, random backpressure and random last flags.
        repeat (400) begin
            bus.req_valid = 4'($urandom);
            bus.req_last  = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                bus.req_data[i] = {8'($urandom), 8'($urandom), 8'($urandom)};
            end
            cycle();
        end

        bus.req_valid = '0;
        bus.req_last  = '1;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

`ifdef XYZ_ARB_LOCK_EN
        // Requester 1 holds the channel for three beats while 0 and 3 wait.
        bus.req_valid = 4'b0001;
        cycle();
        bus.req_valid = 4'b1011;
        acc_q.delete();
        for (int k = 0; k < 5; k++) begin
            bus.req_last[1] = (k >= 2);
            if (k >= 3) bus.req_valid[1] = 1'b0;
            cycle();
            if (k < 2) check("lock_mask", bus.req_ready & 4'b1001, 4'b0000);
        end
        check("lock_count", acc_q.size(), 5);
        for (int k = 0; k < acc_q.size() && k < 5; k++) begin
            check("lock_seq", acc_q[k], exp_lock[k]);
        end
        bus.req_valid = '0;
        bus.req_last  = '1;
        cycle();
`endif

        // Reset in the middle of a multi-beat transfer.
        bus.req_valid   = 4'b0010;
        bus.req_last[1] = 1'b0;
        cycle();
        cycle();
        check("pre_rst_valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", bus.out_valid, 1'b0);
        check("async_rst_ready", bus.req_ready, 4'b0000);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = '1;
        bus.req_last  = '1;
        acc_q.delete();
        cycle();
        check("restart_cnt", acc_q.size(), 1);
        if (acc_q.size() > 0) check("restart_idx", acc_q[0], 0);
        bus.req_valid = '0;
        repeat (2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
